// File: rtl/mul_pkg.sv
`default_nettype none
// mul_pkg -- op / signedness encodings shared by the multiplier issue controller.
// Rev 1.0
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_e;

  localparam logic [1:0] UNS_UU = 2'b00;
  localparam logic [1:0] UNS_SS = 2'b01;
  localparam logic [1:0] UNS_SU = 2'b11;

  localparam int LATENCY_DEF = 4;

  function automatic logic [1:0] op_to_uns(input logic [1:0] op);
    logic [1:0] code;
    case (op)
      OP_MULHSU: code = UNS_SU;
      OP_MULHU:  code = UNS_UU;
      default:   code = UNS_SS;
    endcase
    return code;
  endfunction

  // Only MUL returns the low half of the product.
  function automatic logic op_sel_high(input logic [1:0] op);
    return (op != OP_MUL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_resp_fifo.sv
`default_nettype none
// mul_resp_fifo -- circular result buffer with wrapping pointers and occupancy count.
// Rev 1.0
module mul_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer may still accept a push when its head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rptr];

endmodule
`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// mul_issue_ctrl -- credit-based issue/tracking front end for a fixed-latency multiplier.
// Rev 1.0
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int LATENCY = LATENCY_DEF,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  input  logic             flush,
  output logic             mul_valid,
  output logic [1:0]       mul_is_unsigned,
  output logic [XLEN-1:0]  mul_a,
  output logic [XLEN-1:0]  mul_b,
  input  logic [XLEN-1:0]  mul_r_high,
  input  logic [XLEN-1:0]  mul_r_low
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = $clog2(DEPTH + LATENCY + 1);

  logic                 accept;
  logic [LATENCY-1:0]   alive;
  logic [LATENCY-1:0]   sel_high;
  logic [TAG_W-1:0]     trk_tag [LATENCY];
  logic [SUM_W-1:0]     inflight;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [XLEN+TAG_W-1:0] fifo_wdata;
  logic [XLEN+TAG_W-1:0] fifo_head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + SUM_W'(alive[i]);
    end
  end

  // Every op in flight owns a buffer slot, so the multiplier never has to stall.
  assign req_ready       = !flush && ((SUM_W'(fifo_count) + inflight) < SUM_W'(DEPTH));
  assign accept          = req_valid && req_ready;
  assign mul_valid       = accept;
  assign mul_a           = req_a;
  assign mul_b           = req_b;
  assign mul_is_unsigned = op_to_uns(req_op);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      alive <= '0;
    end else begin
      alive[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        alive[i] <= alive[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    sel_high[0] <= op_sel_high(req_op);
    trk_tag[0]  <= req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      sel_high[i] <= sel_high[i-1];
      trk_tag[i]  <= trk_tag[i-1];
    end
  end

  assign fifo_push  = alive[LATENCY-1];
  assign fifo_wdata = {(sel_high[LATENCY-1] ? mul_r_high : mul_r_low), trk_tag[LATENCY-1]};
  assign fifo_pop   = resp_valid && resp_ready;

  mul_resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + TAG_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign resp_valid           = !fifo_empty;
  assign {resp_data, resp_tag} = fifo_head;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`default_nettype none
// tb_mul_issue_ctrl -- scoreboard bench with a behavioural multiplier and reference model.
module tb_mul_issue_ctrl;
  import mul_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             flush;
  logic             mul_valid;
  logic [1:0]       mul_is_unsigned;
  logic [XLEN-1:0]  mul_a;
  logic [XLEN-1:0]  mul_b;
  logic [XLEN-1:0]  mul_r_high;
  logic [XLEN-1:0]  mul_r_low;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .flush(flush),
    .mul_valid(mul_valid), .mul_is_unsigned(mul_is_unsigned),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_r_high(mul_r_high), .mul_r_low(mul_r_low)
  );

  int n_cmp  = 0;
  int n_err  = 0;
  int n_resp = 0;

  typedef struct { logic [XLEN-1:0] data; logic [TAG_W-1:0] tag; } exp_t;
  exp_t sbq[$];

  // Behavioural multiplier: signedness comes only from the mul_is_unsigned code.
  function automatic logic [63:0] mult_model(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = (code != 2'b00 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    eb = (code == 2'b01 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    return ea * eb;
  endfunction

  logic [63:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_valid ? mult_model(mul_is_unsigned, mul_a, mul_b) : {$urandom, $urandom};
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_r_high = mpipe[LAT-1][63:32];
  assign mul_r_low  = mpipe[LAT-1][31:0];

  // Reference result straight from the instruction definitions.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      2'd0:    p = ua * ub;
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    pv = p;
    return (op == 2'd0) ? pv[31:0] : pv[63:32];
  endfunction

  function automatic logic [1:0] exp_code(input logic [1:0] op);
    case (op)
      2'd2:    return 2'b11;
      2'd3:    return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (resp_valid && resp_ready) begin
        n_cmp++;
        n_resp++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL resp_unexpected: got data %0h tag %0d expected no response", resp_data, resp_tag);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (resp_data !== e.data || resp_tag !== e.tag) begin
            n_err++;
            $display("FAIL resp_data: got %0h tag %0d expected %0h tag %0d", resp_data, resp_tag, e.data, e.tag);
          end
        end
      end
      n_cmp++;
      if (mul_valid !== (req_valid && req_ready)) begin
        n_err++;
        $display("FAIL mul_valid: got %0b expected %0b", mul_valid, req_valid && req_ready);
      end
      if (mul_valid) begin
        n_cmp++;
        if (mul_is_unsigned !== exp_code(req_op) || mul_a !== req_a || mul_b !== req_b) begin
          n_err++;
          $display("FAIL mul_side: got code %b a %0h b %0h expected code %b a %0h b %0h",
                   mul_is_unsigned, mul_a, mul_b, exp_code(req_op), req_a, req_b);
        end
      end
      if (req_valid && req_ready) begin
        exp_t e;
        e.data = ref_result(req_op, req_a, req_b);
        e.tag  = req_tag;
        sbq.push_back(e);
      end
      if (flush) sbq.delete();
    end
  end

  // Called just after a rising edge; returns just after the edge following acceptance.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output bit ok);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!ok) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue_wait(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    bit ok;
    bit seen;
    int cycles;
    issue(op, a, b, tag, ok);
    cycles = 1;
    seen   = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cycles++;
      end
    end
    check({name, "_latency"}, 64'(cycles), 64'(LAT + 1));
    check({name, "_data"}, 64'(resp_data), 64'(exp));
    check({name, "_tag"}, 64'(resp_tag), 64'(tag));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int k;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    k = 0;
    while ((sbq.size() != 0 || resp_valid) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (LAT + 2) @(posedge clk);
    #1;
    check({name, "_drained"}, 64'(sbq.size()), 64'd0);
    check({name, "_resp_idle"}, 64'(resp_valid), 64'd0);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc, lo, cnt, base;
    logic [1:0]  sop [6];
    logic [31:0] sa [6];
    logic [31:0] sb [6];

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    resp_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mul_valid", 64'(mul_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_tag", 64'(resp_tag), 64'd0);
    @(posedge clk); #1;

    resp_ready = 1'b1;
    issue_wait("mul",    2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFE);
    issue_wait("mulh",   2'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000);
    issue_wait("mulhu",  2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE);
    issue_wait("mulhsu", 2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6, 32'hFFFF_FFFF);

    // Back-pressure: six requests with the consumer stalled.
    for (int i = 0; i < 6; i++) begin
      sop[i] = 2'($urandom_range(0, 3)); sa[i] = rand_opnd(); sb[i] = rand_opnd();
    end
    resp_ready = 1'b0;
    acc = 0; lo = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_op = sop[acc]; req_a = sa[acc]; req_b = sb[acc]; req_tag = 5'(10 + acc);
      @(negedge clk);
      if (req_ready) acc++; else lo++;
      @(posedge clk); #1;
    end
    check("bp_accepted", 64'(acc), 64'd4);
    check("bp_ready_low", 64'(lo), 64'd2);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_ready) cnt++;
      @(posedge clk); #1;
    end
    check("bp_still_stalled", 64'(cnt), 64'd0);
    resp_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    check("bp_fifth_accepted", 64'(ok), 64'd1);
    drain("bp");

    // Flush with two ops in flight and a request presented in the flush cycle.
    req_valid = 1'b1; req_op = 2'd0; req_a = 32'd7; req_b = 32'd9; req_tag = 5'd1;
    @(negedge clk); check("fl_acc1", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_tag = 5'd2;
    @(negedge clk); check("fl_acc2", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_tag = 5'd7;
    @(negedge clk);
    check("fl_ready_low", 64'(req_ready), 64'd0);
    check("fl_no_issue", 64'(mul_valid), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("fl_ready_after", 64'(req_ready), 64'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    check("fl_no_resp", 64'(cnt), 64'd0);
    @(posedge clk); #1;

    // Pointer wrap: sixteen ops under a randomly stalling consumer.
    base = n_resp; acc = 0;
    for (int k = 0; k < 300 && acc < 16; k++) begin
      req_valid = 1'b1; req_op = 2'($urandom_range(0, 3)); req_a = rand_opnd(); req_b = rand_opnd();
      req_tag = 5'(acc); resp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    drain("wrap");
    check("wrap_count", 64'(n_resp - base), 64'd16);

    // Reset with three ops in flight.
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_op = 2'd0; req_a = 32'(i + 3); req_b = 32'd5; req_tag = 5'(20 + i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; resp_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    check("rst_mid_no_resp", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    issue_wait("post_rst", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_op     = 2'($urandom_range(0, 3));
      req_a      = rand_opnd();
      req_b      = rand_opnd();
      req_tag    = 5'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 49) == 0);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
